// File: rtl/mel_filterbank_pkg.sv
// rtl/mel_filterbank_pkg.sv - shared widths, band/weight table and output saturation for the mel filterbank
package mel_filterbank_pkg;

    localparam int I_BW     = 32;
    localparam int O_BW     = 32;
    localparam int NUM_BINS = 256;
    localparam int NUM_FILT = 32;
    localparam int W_BW     = 9;
    localparam int ACC_BW   = 49;

    localparam int BIN_BW = $clog2(NUM_BINS);
    localparam int K_BW   = $clog2(NUM_FILT + 1);
    localparam int P_BW   = I_BW + W_BW;

    // Table layout: bins 0..3 sit below filter 0, bands 1..31 are 8 bins wide
    // with weights 32..256, bins 252..255 belong wholly to band NUM_FILT.
    localparam int LO_EDGE = 4;
    localparam int HI_EDGE = 252;

    typedef struct packed {
        logic [K_BW-1:0] k;
        logic [W_BW-1:0] w;
    } coef_t;

    function automatic coef_t coef_lookup(input logic [BIN_BW-1:0] bin);
        coef_t             c;
        logic [BIN_BW-1:0] off;
        logic [3:0]        pos;
        c   = '0;
        off = bin - BIN_BW'(LO_EDGE);
        pos = {1'b0, off[2:0]} + 4'd1;
        if (bin >= BIN_BW'(HI_EDGE)) begin
            c.k = K_BW'(NUM_FILT);
            c.w = W_BW'(256);
        end else if (bin >= BIN_BW'(LO_EDGE)) begin
            c.k = K_BW'(off >> 3) + K_BW'(1);
            c.w = {pos, 5'b0};
        end
        return c;
    endfunction

    function automatic logic [O_BW-1:0] sat_out(input logic [ACC_BW-1:0] acc);
        logic [ACC_BW-9:0] sh;
        sh = acc[ACC_BW-1:8];
        if (|sh[ACC_BW-9:O_BW]) return '1;
        return sh[O_BW-1:0];
    endfunction

endpackage

// File: rtl/mel_coef_rom.sv
// rtl/mel_coef_rom.sv - combinational bin to {band, weight} lookup
module mel_coef_rom
    import mel_filterbank_pkg::*;
(
    input  logic [BIN_BW-1:0] bin,
    output logic [K_BW-1:0]   k,
    output logic [W_BW-1:0]   w
);

    coef_t c;

    assign c = coef_lookup(bin);
    assign k = c.k;
    assign w = c.w;

endmodule

// File: rtl/mel_filterbank.sv
// rtl/mel_filterbank.sv - streaming triangular mel filterbank with two-register sliding accumulator
module mel_filterbank
    import mel_filterbank_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [I_BW-1:0] data_i,
    input  logic            valid_i,
    input  logic            last_i,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o,
    output logic            last_o
);

    logic rst;
    assign rst = rst_i | ~en_i;

    logic [BIN_BW-1:0] bin_q;
    logic [K_BW-1:0]   rom_k;
    logic [W_BW-1:0]   rom_w;

    mel_coef_rom u_rom (
        .bin (bin_q),
        .k   (rom_k),
        .w   (rom_w)
    );

    logic [I_BW-1:0] s0_data;
    logic [K_BW-1:0] s0_k;
    logic [W_BW-1:0] s0_w;
    logic            s0_valid, s0_last;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            bin_q    <= '0;
            s0_data  <= '0;
            s0_k     <= '0;
            s0_w     <= '0;
            s0_valid <= 1'b0;
            s0_last  <= 1'b0;
        end else begin
            s0_valid <= valid_i;
            s0_last  <= valid_i & last_i;
            if (valid_i) begin
                s0_data <= data_i;
                s0_k    <= rom_k;
                s0_w    <= rom_w;
                if (last_i || bin_q == BIN_BW'(NUM_BINS - 1))
                    bin_q <= '0;
                else
                    bin_q <= bin_q + BIN_BW'(1);
            end
        end
    end

    logic [P_BW-1:0] s1_p_hi, s1_p_lo;
    logic [K_BW-1:0] s1_k;
    logic            s1_valid, s1_last;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            s1_p_hi  <= '0;
            s1_p_lo  <= '0;
            s1_k     <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
            s1_last  <= s0_last;
            if (s0_valid) begin
                s1_p_hi <= P_BW'(s0_data) * P_BW'(s0_w);
                s1_p_lo <= P_BW'(s0_data) * P_BW'(W_BW'(256) - s0_w);
                s1_k    <= s0_k;
            end
        end
    end

    logic [ACC_BW-1:0] acc_hi, acc_lo, acc_hi_n, acc_lo_n, flush_q;
    logic [K_BW-1:0]   k_prev;
    logic              flush_pend, step, emit;

    // acc_hi tracks filter k_prev, acc_lo tracks filter k_prev-1; a band step retires acc_lo.
    always_comb begin
        step = s1_valid && (s1_k != k_prev);
        emit = step && (k_prev != '0);
        if (step) begin
            acc_lo_n = acc_hi + ACC_BW'(s1_p_lo);
            acc_hi_n = ACC_BW'(s1_p_hi);
        end else begin
            acc_lo_n = acc_lo + ACC_BW'(s1_p_lo);
            acc_hi_n = acc_hi + ACC_BW'(s1_p_hi);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            acc_hi     <= '0;
            acc_lo     <= '0;
            k_prev     <= '0;
            flush_q    <= '0;
            flush_pend <= 1'b0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
        end else begin
            data_o     <= '0;
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            flush_pend <= 1'b0;
            if (flush_pend) begin
                data_o  <= sat_out(flush_q);
                valid_o <= 1'b1;
                last_o  <= 1'b1;
            end else if (emit) begin
                data_o  <= sat_out(acc_lo);
                valid_o <= 1'b1;
            end
            if (s1_valid) begin
                if (s1_last) begin
                    flush_q    <= acc_lo_n;
                    flush_pend <= 1'b1;
                    acc_hi     <= '0;
                    acc_lo     <= '0;
                    k_prev     <= '0;
                end else begin
                    acc_hi <= acc_hi_n;
                    acc_lo <= acc_lo_n;
                    k_prev <= s1_k;
                end
            end
        end
    end

endmodule

// File: tb/tb_mel_filterbank.sv
// tb/tb_mel_filterbank.sv - directed self-checking bench for mel_filterbank
module tb_mel_filterbank;
    import mel_filterbank_pkg::*;

    typedef struct packed {
        logic [31:0] val;
        logic        last;
        logic [31:0] cyc;
    } beat_t;

    logic            clk_i = 1'b0;
    logic            rst_i, en_i, valid_i, last_i;
    logic [I_BW-1:0] data_i;
    logic [O_BW-1:0] data_o;
    logic            valid_o, last_o;

    logic [BIN_BW-1:0] chk_bin;
    logic [K_BW-1:0]   chk_k;
    logic [W_BW-1:0]   chk_w;

    int          n_checks = 0;
    int          n_errors = 0;
    int          nz_cnt   = 0;
    logic [31:0] cyc      = 0;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    logic [31:0] frm [NUM_BINS];
    logic [31:0] drv [NUM_BINS];
    int          tk  [NUM_BINS];
    int          tw  [NUM_BINS];

    mel_filterbank u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o)
    );

    mel_coef_rom u_rom_chk (
        .bin (chk_bin),
        .k   (chk_k),
        .w   (chk_w)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        beat_t b;
        if (valid_o) begin
            b.val  = data_o;
            b.last = last_o;
            b.cyc  = cyc;
            obs_q.push_back(b);
        end else if (data_o != 0 || last_o) begin
            nz_cnt <= nz_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_bin(input logic [31:0] d, input logic lst);
        data_i  = d;
        valid_i = 1'b1;
        last_i  = lst;
        @(posedge clk_i);
        #1;
        data_i  = '0;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    function automatic logic [31:0] sat_ref(input logic [63:0] s);
        logic [63:0] y;
        y = s >> 8;
        return (y > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : y[31:0];
    endfunction

    // Direct per-filter sums over the received bins; outputs follow band arrival order.
    task automatic model_frame(input int len);
        logic [63:0] s [NUM_FILT+1];
        beat_t       b;
        int          kl, fb;
        for (int f = 0; f <= NUM_FILT; f++) s[f] = 0;
        for (int i = 0; i < len; i++) begin
            s[tk[i]] += 64'(frm[i]) * 64'(tw[i]);
            if (tk[i] >= 1) s[tk[i]-1] += 64'(frm[i]) * 64'(256 - tw[i]);
        end
        kl = tk[len-1];
        for (int f = 0; f < kl - 1; f++) begin
            fb = 0;
            for (int i = len - 1; i >= 0; i--) if (tk[i] == f + 2) fb = i;
            b.val  = sat_ref(s[f]);
            b.last = 1'b0;
            b.cyc  = drv[fb] + 3;
            exp_q.push_back(b);
        end
        b.val  = sat_ref(s[kl-1]);
        b.last = 1'b1;
        b.cyc  = drv[len-1] + 4;
        exp_q.push_back(b);
    endtask

    task automatic send_frame(input int len, input bit with_last, input int duty);
        int g;
        for (int i = 0; i < len; i++) begin
            g = 0;
            while (duty < 100 && g < 8 && $urandom_range(99) >= duty) begin
                idle();
                g++;
            end
            drv[i] = cyc;
            drive_bin(frm[i], with_last && (i == len - 1));
        end
        if (with_last) model_frame(len);
    endtask

    task automatic compare_all(input string tag);
        repeat (12) idle();
        check($sformatf("%s_cnt", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_val%0d", tag, i), 64'(obs_q[i].val), 64'(exp_q[i].val));
            check($sformatf("%s_last%0d", tag, i), 64'(obs_q[i].last), 64'(exp_q[i].last));
            check($sformatf("%s_lat%0d", tag, i), 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
        end
    endtask

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic fill_random(input int max_shift);
        for (int i = 0; i < NUM_BINS; i++) frm[i] = $urandom() >> $urandom_range(max_shift);
    endtask

    initial begin
        int viol, nlast;
        rst_i   = 1'b1;
        en_i    = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        chk_bin = '0;

        for (int i = 0; i < NUM_BINS; i++) begin
            if (i < 4) begin
                tk[i] = 0;  tw[i] = 0;
            end else if (i >= 252) begin
                tk[i] = 32; tw[i] = 256;
            end else begin
                tk[i] = (i - 4) / 8 + 1;
                tw[i] = ((i - 4) % 8 + 1) * 32;
            end
        end

        viol = 0;
        for (int i = 0; i < NUM_BINS; i++) begin
            chk_bin = BIN_BW'(i);
            #1;
            check($sformatf("rom_k%0d", i), 64'(chk_k), 64'(tk[i]));
            check($sformatf("rom_w%0d", i), 64'(chk_w), 64'(tw[i]));
            if (i == 0 && chk_k != 0) viol++;
            if (i == NUM_BINS - 1 && chk_k != K_BW'(NUM_FILT)) viol++;
            if (i > 0 && (int'(chk_k) < tk[i-1] || int'(chk_k) > tk[i-1] + 1)) viol++;
            if (chk_k == 0 && chk_w != 0) viol++;
            if (chk_k == K_BW'(NUM_FILT) && chk_w != W_BW'(256)) viol++;
            if (chk_w > W_BW'(256)) viol++;
        end
        check("tbl_invariants", 64'(viol), 64'(0));

        repeat (3) idle();
        check("rst_data", 64'(data_o), 64'(0));
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_last", 64'(last_o), 64'(0));
        rst_i = 1'b0;
        idle();

        fill_random(12);
        send_frame(60, 1'b0, 100);
        rst_i = 1'b1;
        idle();
        clear_q();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rst_mid_data%0d", c), 64'(data_o), 64'(0));
            check($sformatf("rst_mid_valid%0d", c), 64'(valid_o), 64'(0));
            check($sformatf("rst_mid_last%0d", c), 64'(last_o), 64'(0));
            if (c < 2) idle();
        end
        rst_i = 1'b0;
        repeat (8) idle();
        check("rst_discard_cnt", 64'(obs_q.size()), 64'(0));
        fill_random(16);
        send_frame(NUM_BINS, 1'b1, 100);
        compare_all("post_rst");
        clear_q();

        for (int i = 0; i < NUM_BINS; i++) frm[i] = 0;
        frm[37] = 1000;
        send_frame(NUM_BINS, 1'b1, 100);
        compare_all("impulse");
        if (obs_q.size() == 32) begin
            nlast = 0;
            for (int i = 0; i < 32; i++) nlast += int'(obs_q[i].last);
            check("imp_f4", 64'(obs_q[4].val), 64'(750));
            check("imp_f5", 64'(obs_q[5].val), 64'(250));
            check("imp_f3", 64'(obs_q[3].val), 64'(0));
            check("imp_f6", 64'(obs_q[6].val), 64'(0));
            check("imp_last_cnt", 64'(nlast), 64'(1));
            check("imp_last31", 64'(obs_q[31].last), 64'(1));
        end
        clear_q();

        for (int i = 0; i < NUM_BINS; i++) frm[i] = 32'hFFFF_FFFF;
        send_frame(NUM_BINS, 1'b1, 100);
        compare_all("sat");
        if (obs_q.size() == 32) begin
            check("sat_f0", 64'(obs_q[0].val), 64'hFFFF_FFFF);
            check("sat_f31", 64'(obs_q[31].val), 64'hFFFF_FFFF);
        end
        clear_q();

        fill_random(8);
        send_frame(NUM_BINS, 1'b1, 100);
        fill_random(20);
        send_frame(NUM_BINS, 1'b1, 100);
        compare_all("b2b");
        clear_q();

        fill_random(16);
        send_frame(NUM_BINS, 1'b1, 30);
        compare_all("gap");
        clear_q();

        fill_random(16);
        send_frame(100, 1'b0, 100);
        data_i  = 32'h1234;
        valid_i = 1'b1;
        en_i    = 1'b0;
        idle();
        check("en_data", 64'(data_o), 64'(0));
        check("en_valid", 64'(valid_o), 64'(0));
        check("en_last", 64'(last_o), 64'(0));
        en_i    = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        clear_q();
        repeat (8) idle();
        check("en_discard_cnt", 64'(obs_q.size()), 64'(0));
        fill_random(16);
        send_frame(NUM_BINS, 1'b1, 100);
        compare_all("post_en");
        clear_q();

        fill_random(16);
        send_frame(101, 1'b1, 100);
        compare_all("short");
        if (obs_q.size() == 13) check("short_last", 64'(obs_q[12].last), 64'(1));
        clear_q();

        check("idle_zero", 64'(nz_cnt), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
